// File: rtl/pb_io_responder.sv
// pb_io_responder: KCPSM6 port-mapped responder with GPIO, scratch, ID and an interrupting reload timer.
module pb_io_responder #(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         PRESCALE   = 16,
    parameter logic [7:0] GPIO_RESET = 8'h00,
    parameter logic [7:0] ID_VALUE   = 8'hB1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out
);
    typedef enum logic {S_IDLE, S_ASSERT} irq_state_t;
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    irq_state_t irq_q, irq_d;
    logic [7:0] in_port_q, in_port_d, gpio_out_q, gpio_out_d, reload_q, reload_d;
    logic [7:0] count_q, count_d, scratch_q, scratch_d;
    logic [15:0] sync_q, sync_d, pre_q, pre_d;
    logic ten_q, ten_d, ien_q, ien_d, exp_q, exp_d, interrupt_q, interrupt_d;
    logic [2:0] off;
    logic hit, wr, rd, ctrl_wr, tick, expire, ten_rise, ien_clr, status_clr;
    always_comb begin
        off = port_id[2:0];
        hit = port_id[7:3] == BASE_ADDR[7:3];
        wr = write_strobe && hit;
        rd = read_strobe && hit;
        ctrl_wr = wr && off == 3'd3;
        tick = ten_q && pre_q == PRE_LAST;
        expire = tick && count_q == 8'd0;
        ten_rise = ctrl_wr && out_port[0] && !ten_q;
        ien_clr = ctrl_wr && !out_port[1];
        status_clr = off == 3'd4 && (rd || (wr && out_port[0]));
        sync_d = {sync_q[7:0], gpio_in};
        gpio_out_d = (wr && off == 3'd0) ? out_port : gpio_out_q;
        reload_d = (wr && off == 3'd2) ? out_port : reload_q;
        scratch_d = (wr && off == 3'd6) ? out_port : scratch_q;
        ten_d = ctrl_wr ? out_port[0] : ten_q;
        ien_d = ctrl_wr ? out_port[1] : ien_q;
        // Prescaler only advances while enabled, so a TEN 0->1 write always starts it from zero
        pre_d = (ten_q && !tick) ? pre_q + 16'd1 : 16'd0;
        count_d = ten_rise ? reload_q : !tick ? count_q : expire ? reload_q : count_q - 8'd1;
        exp_d = expire || (exp_q && !status_clr);
        irq_d = (irq_q == S_IDLE) ? ((expire && ien_q) ? S_ASSERT : S_IDLE)
              : (ien_clr || (interrupt_ack && !expire)) ? S_IDLE : S_ASSERT;
        interrupt_d = irq_q == S_ASSERT;
        in_port_d = 8'h00;
        if (hit)
            case (off)
                3'd0: in_port_d = gpio_out_q;
                3'd1: in_port_d = sync_q[15:8];
                3'd2: in_port_d = reload_q;
                3'd3: in_port_d = {6'd0, ien_q, ten_q};
                3'd4: in_port_d = {6'd0, irq_q == S_ASSERT, exp_q};
                3'd5: in_port_d = count_q;
                3'd6: in_port_d = scratch_q;
                3'd7: in_port_d = ID_VALUE;
            endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= S_IDLE;
            in_port_q <= 8'h00;
            gpio_out_q <= GPIO_RESET;
            reload_q <= 8'h00;
            count_q <= 8'h00;
            scratch_q <= 8'h00;
            sync_q <= 16'h0000;
            pre_q <= 16'h0000;
            ten_q <= 1'b0;
            ien_q <= 1'b0;
            exp_q <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
            in_port_q <= in_port_d;
            gpio_out_q <= gpio_out_d;
            reload_q <= reload_d;
            count_q <= count_d;
            scratch_q <= scratch_d;
            sync_q <= sync_d;
            pre_q <= pre_d;
            ten_q <= ten_d;
            ien_q <= ien_d;
            exp_q <= exp_d;
            interrupt_q <= interrupt_d;
        end
    end
    assign in_port = in_port_q;
    assign interrupt = interrupt_q;
    assign gpio_out = gpio_out_q;
endmodule
